// File: rtl/activation_derivative_if.sv
// activation_derivative_if: valid/ready input and output channels of the activation derivative block.
// err_data exists only when GRAD_MUL_EN is defined.
interface activation_derivative_if #(
  parameter int data_size = 16,
  parameter int size = 3,
  parameter int activate_size = 4
);
  logic in_valid;
  logic in_ready;
  logic [data_size*size-1:0] in_data;
  logic [activate_size-1:0] act;
`ifdef GRAD_MUL_EN
  logic [data_size*size-1:0] err_data;
`endif
  logic out_valid;
  logic out_ready;
  logic [data_size*size-1:0] out_data;
  modport master (
`ifdef GRAD_MUL_EN
    output err_data,
`endif
    output in_valid, in_data, act, out_ready,
    input in_ready, out_valid, out_data
  );
  modport slave (
`ifdef GRAD_MUL_EN
    input err_data,
`endif
    input in_valid, in_data, act, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/activation_derivative.sv
// activation_derivative: serial per-lane f'(y) for LINEAR/BINARY/SIGMOID/TANH on one shared multiplier.
// GRAD_MUL_EN: also multiplies each derivative by the latched error lane (two cycles per lane).
module activation_derivative #(
  parameter int data_size = 16,
  parameter int frac_bits = 8,
  parameter int size = 3,
  parameter int activate_size = 4
) (
  input logic clk,
  input logic reset,
  activation_derivative_if.slave bus
);
  localparam int ds = data_size;
  localparam int lw = size > 1 ? $clog2(size) : 1;
  localparam logic [lw-1:0] last = lw'(size - 1);
  localparam logic signed [ds-1:0] smax = {1'b0, {(ds-1){1'b1}}};
  localparam logic signed [ds-1:0] smin = {1'b1, {(ds-1){1'b0}}};
  localparam logic signed [ds-1:0] one = ds'(1 << frac_bits);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [lw-1:0] lane;
  logic [ds*size-1:0] y_reg;
  logic [activate_size-1:0] act_reg;
  logic signed [ds-1:0] res [size];
  logic signed [ds-1:0] y_lanes [size];
  logic signed [ds-1:0] y_cur, ma, mb, mres, d, res_val;
  logic signed [2*ds-1:0] prod, shifted;
  logic signed [ds:0] dy, d1;
  logic wr;
`ifdef GRAD_MUL_EN
  logic [ds*size-1:0] e_reg;
  logic signed [ds-1:0] e_lanes [size];
  logic phase;
  logic signed [ds-1:0] d_reg;
`endif
  function automatic logic signed [ds-1:0] sat1(input logic signed [ds:0] v);
    return v > (ds+1)'(smax) ? smax : v < (ds+1)'(smin) ? smin : v[ds-1:0];
  endfunction
  for (genvar g = 0; g < size; g++) begin : g_lane
    assign y_lanes[g] = y_reg[(size-g)*ds-1 -: ds];
    assign bus.out_data[(size-g)*ds-1 -: ds] = res[g];
`ifdef GRAD_MUL_EN
    assign e_lanes[g] = e_reg[(size-g)*ds-1 -: ds];
`endif
  end
  // Phase 0 squares y; phase 1 (gradient build only) multiplies err by the held derivative.
  always_comb begin
    y_cur = y_lanes[lane];
`ifdef GRAD_MUL_EN
    ma = phase ? e_lanes[lane] : y_cur;
    mb = phase ? d_reg : y_cur;
`else
    ma = y_cur;
    mb = y_cur;
`endif
    prod = ma * mb;
    shifted = prod >>> frac_bits;
    mres = shifted > (2*ds)'(smax) ? smax : shifted < (2*ds)'(smin) ? smin : shifted[ds-1:0];
    dy = (ds+1)'(y_cur) - (ds+1)'(mres);
    d1 = (ds+1)'(one) - (ds+1)'(mres);
    d = act_reg == activate_size'(2) ? sat1(dy) :
        act_reg == activate_size'(3) ? sat1(d1) :
        act_reg == activate_size'(1) ? '0 : one;
`ifdef GRAD_MUL_EN
    wr = phase;
    res_val = mres;
`else
    wr = 1'b1;
    res_val = d;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      lane <= '0;
      y_reg <= '0;
      act_reg <= '0;
      res <= '{default: '0};
`ifdef GRAD_MUL_EN
      e_reg <= '0;
      phase <= 1'b0;
      d_reg <= '0;
`endif
    end else
      case (state)
        IDLE: if (bus.in_valid) begin
          y_reg <= bus.in_data;
          act_reg <= bus.act;
`ifdef GRAD_MUL_EN
          e_reg <= bus.err_data;
          phase <= 1'b0;
`endif
          lane <= '0;
          bus.in_ready <= 1'b0;
          state <= CALC;
        end
        CALC: begin
          if (wr) begin
            res[lane] <= res_val;
            lane <= lane == last ? '0 : lane + 1'b1;
            if (lane == last) begin
              state <= DONE;
              bus.out_valid <= 1'b1;
            end
          end
`ifdef GRAD_MUL_EN
          phase <= !phase;
          if (!phase) d_reg <= d;
`endif
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_activation_derivative.sv
// tb_activation_derivative: scoreboard bench for activation_derivative (Q8.8, 3 lanes).
// Define GRAD_MUL_EN to exercise the error-multiply build.
module tb_activation_derivative;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  logic [47:0] q [$];
`ifdef GRAD_MUL_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 4;
`endif
  localparam logic [47:0] E1 = {3{16'h0100}};
  activation_derivative_if #(.data_size(16), .size(3), .activate_size(4)) bus ();
  activation_derivative #(.data_size(16), .frac_bits(8), .size(3), .activate_size(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;

  function automatic longint clamp(input longint v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction
  function automatic logic [15:0] mlane(input logic [15:0] yv, input logic [3:0] a, input logic [15:0] ev);
    longint y = longint'($signed(yv));
    longint sq = clamp((y * y) >>> 8);
    longint dv = a == 2 ? clamp(y - sq) : a == 3 ? clamp(256 - sq) : a == 1 ? 0 : 256;
`ifdef GRAD_MUL_EN
    dv = clamp((longint'($signed(ev)) * dv) >>> 8);
`else
    if (ev === 16'hxxxx) dv = 0;
`endif
    return 16'(dv);
  endfunction
  function automatic logic [47:0] mvec(input logic [47:0] y, input logic [3:0] a, input logic [47:0] e);
    return {mlane(y[47:32], a, e[47:32]), mlane(y[31:16], a, e[31:16]), mlane(y[15:0], a, e[15:0])};
  endfunction

  task automatic send(input logic [47:0] y, input logic [3:0] a, input logic [47:0] e, input logic [47:0] x);
    int n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.in_valid = 1; bus.in_data = y; bus.act = a;
`ifdef GRAD_MUL_EN
    bus.err_data = e;
`endif
    @(posedge clk); #1;
    bus.in_valid = 0;
    q.push_back(x);
  endtask
  task automatic collect(output logic [47:0] got, output int lat, output bit ok);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    ok = bus.out_valid; got = bus.out_data;
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
  endtask

  task automatic test_reset;
    bus.in_valid = 0; bus.out_ready = 0; bus.in_data = '0; bus.act = '0;
`ifdef GRAD_MUL_EN
    bus.err_data = '0;
`endif
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 48'h0) begin errors++; $display("FAIL reset out_data got %h exp 0", bus.out_data); end
  endtask

  task automatic test_sigmoid;
    logic [47:0] got, x; int lat; bit ok;
    send({3{16'h0080}}, 4'd2, E1, {3{16'h0040}});
    bus.in_data = {3{16'h7777}}; bus.act = 4'd0;
    collect(got, lat, ok);
    x = q.pop_front();
    checks++; if (!ok || got !== x) begin errors++; $display("FAIL sigmoid data got %h exp %h", got, x); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL sigmoid latency got %0d exp %0d", lat, LAT); end
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL post_handshake out_valid/in_ready got %b%b exp 01", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_tanh;
    logic [47:0] got, x; int lat; bit ok;
    send({16'h0080, 16'h0000, 16'h8000}, 4'd3, E1, {16'h00C0, 16'h0100, 16'h8101});
    collect(got, lat, ok);
    x = q.pop_front();
    checks++; if (!ok || got !== x) begin errors++; $display("FAIL tanh data got %h exp %h", got, x); end
  endtask

  task automatic test_acts;
    logic [47:0] got, x; int lat; bit ok;
    logic [3:0] acts [3] = '{4'd0, 4'd1, 4'd7};
    logic [47:0] exps [3] = '{{3{16'h0100}}, 48'h0, {3{16'h0100}}};
    for (int i = 0; i < 3; i++) begin
      send({16'h0080, 16'h1234, 16'hF000}, acts[i], E1, exps[i]);
      collect(got, lat, ok);
      x = q.pop_front();
      checks++; if (!ok || got !== x) begin errors++; $display("FAIL act%0d data got %h exp %h", acts[i], got, x); end
    end
  endtask

  task automatic test_back_to_back;
    logic [47:0] got, x; int lat, n; bit ok;
    send({3{16'h0080}}, 4'd2, E1, {3{16'h0040}});
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    x = q.pop_front();
    bus.in_valid = 1; bus.in_data = {16'h0080, 16'h0000, 16'h8000}; bus.act = 4'd3;
`ifdef GRAD_MUL_EN
    bus.err_data = E1;
`endif
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== x || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL stall cycle %0d got v=%b d=%h r=%b exp v=1 d=%h r=0", i, bus.out_valid, bus.out_data, bus.in_ready, x); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1;
    q.push_back({16'h00C0, 16'h0100, 16'h8101});
    @(posedge clk); #1;
    bus.out_ready = 0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL same_cycle in_ready/out_valid got %b%b exp 10", bus.in_ready, bus.out_valid); end
    @(posedge clk); #1;
    bus.in_valid = 0;
    collect(got, lat, ok);
    x = q.pop_front();
    checks++; if (!ok || got !== x) begin errors++; $display("FAIL b2b data got %h exp %h", got, x); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b latency got %0d exp %0d", lat, LAT); end
  endtask

  task automatic test_reset_mid;
    logic [47:0] got, x; int lat; bit ok;
    send({3{16'h0080}}, 4'd3, E1, {3{16'h00C0}});
    @(posedge clk); #2;
    reset = 1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 48'h0) begin
      errors++; $display("FAIL reset_mid got v=%b r=%b d=%h exp v=0 r=1 d=0", bus.out_valid, bus.in_ready, bus.out_data); end
    void'(q.pop_back());
    @(posedge clk); #1 reset = 0;
    send({16'h0080, 16'h0100, 16'hFF00}, 4'd2, E1, mvec({16'h0080, 16'h0100, 16'hFF00}, 4'd2, E1));
    collect(got, lat, ok);
    x = q.pop_front();
    checks++; if (!ok || got !== x) begin errors++; $display("FAIL after_reset data got %h exp %h", got, x); end
  endtask

  task automatic test_random;
    logic [47:0] got, x, y, e; logic [3:0] a; int lat; bit ok;
    for (int i = 0; i < 6; i++) begin
      y = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      e = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      a = 4'($urandom_range(0, 7));
      send(y, a, e, mvec(y, a, e));
      collect(got, lat, ok);
      x = q.pop_front();
      checks++; if (!ok || got !== x) begin errors++; $display("FAIL random%0d act=%0d y=%h got %h exp %h", i, a, y, got, x); end
    end
  endtask

`ifdef GRAD_MUL_EN
  task automatic test_grad;
    logic [47:0] got, x; int lat; bit ok;
    send({3{16'h0080}}, 4'd2, {3{16'h0200}}, {3{16'h0080}});
    collect(got, lat, ok);
    x = q.pop_front();
    checks++; if (!ok || got !== x) begin errors++; $display("FAIL grad data got %h exp %h", got, x); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL grad latency got %0d exp 7", lat); end
    // -32768 * 64 >>> 8 = -8192
    send({3{16'h0080}}, 4'd2, {3{16'h8000}}, {3{16'hE000}});
    collect(got, lat, ok);
    x = q.pop_front();
    checks++; if (!ok || got !== x) begin errors++; $display("FAIL grad_neg data got %h exp %h", got, x); end
  endtask
`endif

  initial begin
    test_reset;
    test_sigmoid;
    test_tanh;
    test_acts;
    test_back_to_back;
    test_reset_mid;
    test_random;
`ifdef GRAD_MUL_EN
    test_grad;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
